// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and default sizes for the MAC datapath
package mac_pkg;

    localparam int N_LEN_DEF = 16;
    localparam int Q_LEN_DEF = 8;
    localparam int TAPS_DEF  = 8;
    localparam int AW_DEF    = $clog2(TAPS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tap_ram.sv
// rtl/tap_ram.sv - DEPTH x W register array, one write port, one combinational read port
module tap_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write to raddr returns the old word.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_tap_seq.sv
// rtl/fir_tap_seq.sv - sequences delay-line/coefficient pairs into the MAC, one frame per sample
module fir_tap_seq
    import mac_pkg::*;
#(
    parameter int N_LEN = N_LEN_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int AW    = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             ce,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N_LEN-1:0] s_data,
    input  logic             flush,
    input  logic             coef_we,
    input  logic [AW-1:0]    coef_addr,
    input  logic [N_LEN-1:0] coef_data,
    output logic             busy,
    output logic [N_LEN-1:0] A,
    output logic [N_LEN-1:0] B,
    output logic             sload
);

    seq_state_t       state;
    logic [AW-1:0]    k;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    base;
    logic [AW-1:0]    rd_addr;
    logic             last_tap;
    logic             hs;
    logic             coef_wr_en;
    logic [N_LEN-1:0] dl_rdata;
    logic [N_LEN-1:0] coef_rdata;

    assign last_tap   = (state == RUN) && (k == AW'(TAPS - 1));
    assign s_ready    = ce & ((state == IDLE) | last_tap);
    assign hs         = s_valid & s_ready;
    assign coef_wr_en = ce & coef_we & (state == IDLE);
    assign rd_addr    = base - k;
    assign busy       = (state != IDLE);

    tap_ram #(.W(N_LEN), .DEPTH(TAPS), .AW(AW)) u_dl (
        .clk   (clk),
        .arst_n(arst_n),
        .we    (hs),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (dl_rdata)
    );

    tap_ram #(.W(N_LEN), .DEPTH(TAPS), .AW(AW)) u_coef (
        .clk   (clk),
        .arst_n(arst_n),
        .we    (coef_wr_en),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (k),
        .rdata (coef_rdata)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            k      <= '0;
            wr_ptr <= '0;
            base   <= '0;
            A      <= '0;
            B      <= '0;
            sload  <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    A     <= '0;
                    B     <= '0;
                    sload <= 1'b0;
                    if (hs) begin
                        state <= RUN;
                    end else if (flush) begin
                        state <= FLUSH;
                    end
                end
                RUN: begin
                    A     <= dl_rdata;
                    B     <= coef_rdata;
                    sload <= (k == '0);
                    k     <= k + 1'b1;
                    if (last_tap) begin
                        state <= hs ? RUN : IDLE;
                    end
                end
                FLUSH: begin
                    // Zero pair with sload closes the MAC's running dot product.
                    A     <= '0;
                    B     <= '0;
                    sload <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (hs) begin
                base   <= wr_ptr;
                wr_ptr <= wr_ptr + 1'b1;
                k      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_seq.sv
// tb/tb_fir_tap_seq.sv - self-checking bench for fir_tap_seq against a sample-history model
module tb_fir_tap_seq;

    localparam int N_LEN = 16;
    localparam int TAPS  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             ce = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [N_LEN-1:0] s_data = '0;
    logic             flush = 1'b0;
    logic             coef_we = 1'b0;
    logic [AW-1:0]    coef_addr = '0;
    logic [N_LEN-1:0] coef_data = '0;
    logic             busy;
    logic [N_LEN-1:0] A;
    logic [N_LEN-1:0] B;
    logic             sload;

    fir_tap_seq #(.N_LEN(N_LEN), .TAPS(TAPS), .AW(AW)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .ce       (ce),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .flush    (flush),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .busy     (busy),
        .A        (A),
        .B        (B),
        .sload    (sload)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sl;
        logic        fl;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] hist[$];
    logic [15:0] coef_m[TAPS];
    pair_t       cur;
    logic        last_hs;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic ready_m();
        return ce && (exp_q.size() == 0 || (exp_q.size() == 1 && !exp_q[0].fl));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 16'h0;
        cur = '{16'h0, 16'h0, 1'b0, 1'b0};
    endtask

    // One clock: drive inputs, check s_ready, advance model, check registered outputs.
    task automatic tick(input logic v, input logic [15:0] d, input logic fl, input logic we,
                        input logic [2:0] ad, input logic [15:0] cd, input logic cen);
        logic hs;
        logic idle;
        int   n;
        s_valid = v; s_data = d; flush = fl;
        coef_we = we; coef_addr = ad; coef_data = cd; ce = cen;
        #1;
        chk("s_ready", 32'(s_ready), 32'(ready_m()));
        hs = v && ready_m();
        idle = (exp_q.size() == 0);
        last_hs = hs;
        if (cen) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{16'h0, 16'h0, 1'b0, 1'b0};
            if (idle && we) coef_m[ad] = cd;
            if (hs) begin
                hist.push_back(d);
                n = hist.size() - 1;
                for (int j = 0; j < TAPS; j++)
                    exp_q.push_back('{(n - j >= 0) ? hist[n - j] : 16'h0, coef_m[j], j == 0, 1'b0});
            end else if (idle && fl) begin
                exp_q.push_back('{16'h0, 16'h0, 1'b1, 1'b1});
            end
        end
        @(posedge clk);
        #1;
        chk("A", 32'(A), 32'(cur.a));
        chk("B", 32'(B), 32'(cur.b));
        chk("sload", 32'(sload), 32'(cur.sl));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    endtask

    task automatic idle_tick(input logic cen);
        tick(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, cen);
    endtask

    task automatic send(input logic [15:0] d, input logic fl);
        int budget;
        budget = 0;
        do begin
            tick(1'b1, d, fl, 1'b0, 3'd0, 16'h0, 1'b1);
            budget++;
        end while (!last_hs && budget < 40);
        if (!last_hs) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: sample %h not accepted within %0d cycles", d, budget);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            idle_tick(1'b1);
            budget++;
        end
        idle_tick(1'b1);
    endtask

    task automatic write_coef(input logic [2:0] ad, input logic [15:0] cd);
        tick(1'b0, 16'h0, 1'b0, 1'b1, ad, cd, 1'b1);
    endtask

    initial begin
        int nb;
        model_reset();
        arst_n = 1'b0;
        ce = 1'b1;
        #3;
        chk("rst_A", 32'(A), 32'h0);
        chk("rst_B", 32'(B), 32'h0);
        chk("rst_sload", 32'(sload), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(s_ready), 32'h1);

        // impulse response
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'((i + 1) << 8));
        send(16'h0100, 1'b0);
        for (int i = 0; i < 7; i++) send(16'h0000, 1'b0);
        drain();

        // back-to-back random streaming
        for (int i = 0; i < 20; i++) send(16'($urandom), 1'b0);
        drain();

        // ce stall at tap 4
        send(16'($urandom), 1'b0);
        nb = busy ? 1 : 0;
        for (int i = 0; i < 14; i++) begin
            idle_tick((i >= 4 && i < 7) ? 1'b0 : 1'b1);
            if (busy) nb++;
        end
        chk("stall_len", 32'(nb), 32'(TAPS + 3));

        // coefficient write during RUN is dropped, in IDLE it lands
        send(16'($urandom), 1'b0);
        idle_tick(1'b1);
        write_coef(3'd2, 16'h7FFF);
        drain();
        send(16'($urandom), 1'b0);
        drain();
        write_coef(3'd2, 16'h7FFF);
        send(16'($urandom), 1'b0);
        drain();

        // flush alone, then flush colliding with a sample
        tick(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1);
        idle_tick(1'b1);
        idle_tick(1'b1);
        send(16'($urandom), 1'b1);
        drain();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom % 2), 16'($urandom), 1'($urandom % 8 == 0), 1'($urandom % 4 == 0),
                 3'($urandom), 16'($urandom), 1'($urandom % 5 != 0));
        end
        drain();

        // asynchronous reset mid-frame
        send(16'h1234, 1'b0);
        idle_tick(1'b1);
        idle_tick(1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("midrst_A", 32'(A), 32'h0);
        chk("midrst_B", 32'(B), 32'h0);
        chk("midrst_sload", 32'(sload), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        model_reset();
        @(posedge clk);
        #3;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 32'(s_ready), 32'h1);
        send(16'($urandom), 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
